// File: rtl/coinc_pkg.sv
// Shared types and helpers for the coincidence counter: FSM states, BCD digit width
// and a generic multi-digit BCD increment.
package coinc_pkg;

  localparam int BCD_W          = 4;
  localparam int BCD_MAX_DIGITS = 8;

  typedef enum logic [1:0] {IDLE, OPEN, HOLDOFF} coinc_state_e;

  // Returns {wrap, next}; only the lowest `digits` digits take part in the carry chain.
  function automatic logic [BCD_MAX_DIGITS*BCD_W:0] bcd_inc(
    input logic [BCD_MAX_DIGITS*BCD_W-1:0] value,
    input int                              digits
  );
    logic [BCD_MAX_DIGITS*BCD_W-1:0] nxt;
    logic                            carry;
    logic [BCD_W-1:0]                d;
    nxt   = value;
    carry = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits && carry) begin
        d = value[i*BCD_W +: BCD_W];
        if (d == 4'd9) begin
          nxt[i*BCD_W +: BCD_W] = '0;
        end else begin
          nxt[i*BCD_W +: BCD_W] = d + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return {carry, nxt};
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// DIGITS-wide BCD event counter with synchronous clear and a sticky wrap flag.
module bcd_counter
  import coinc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  output logic [DIGITS*BCD_W-1:0] value,
  output logic                    wrap
);

  localparam int W = DIGITS * BCD_W;

  logic [W-1:0]                      value_q, value_d;
  logic                              wrap_q, wrap_d;
  logic [BCD_MAX_DIGITS*BCD_W-1:0]   value_ext;
  logic [BCD_MAX_DIGITS*BCD_W:0]     inc_res;

  always_comb begin
    value_ext        = '0;
    value_ext[W-1:0] = value_q;
    inc_res          = bcd_inc(value_ext, DIGITS);
    value_d          = value_q;
    wrap_d           = wrap_q;
    if (clr) begin
      value_d = '0;
      wrap_d  = 1'b0;
    end else if (inc) begin
      value_d = inc_res[W-1:0];
      wrap_d  = wrap_q | inc_res[BCD_MAX_DIGITS*BCD_W];
    end
  end

  generate
    if (DIGITS < BCD_MAX_DIGITS) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^inc_res[BCD_MAX_DIGITS*BCD_W-1:W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  assign value = value_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/coinc_counter_core.sv
// N-channel debounced BCD event counter with windowed coincidence detection.
// Optional coincidence delay measurement is enabled by defining COINC_DT_EN.
//   state   | meaning
//   IDLE    | no window open, waiting for a first masked hit
//   OPEN    | window running, collecting masked hits into seen
//   HOLDOFF | coincidence counted, waiting for all masked levels to drop
module coinc_counter_core
  import coinc_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DIGITS        = 4,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int WINDOW_CYCLES = 100
`ifdef COINC_DT_EN
  ,
  parameter int DT_W          = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_in,
  input  logic [NUM_CH-1:0]          coinc_mask,
  input  logic                       count_en,
  input  logic                       clear,
  output logic [NUM_CH*DIGITS*4-1:0] ch_bcd,
  output logic [DIGITS*4-1:0]        coinc_bcd,
  output logic                       coinc_pulse,
  output logic [NUM_CH:0]            overflow
`ifdef COINC_DT_EN
  ,
  output logic [DT_W-1:0]            coinc_dt,
  output logic                       coinc_dt_valid
`endif
);

  localparam int CW      = DIGITS * BCD_W;
  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TIMER_W = $clog2(WINDOW_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(DEB_CYCLES - 1);

  logic [NUM_CH-1:0] deb_lvl;
  logic [NUM_CH-1:0] hit;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic             sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // Down-counter reloads whenever the synchronised input agrees with the level.
    always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = DEB_LOAD;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == '0) deb_d = sync2_q;
        else                 deb_cnt_d = deb_cnt_q - DEB_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        deb_cnt_q  <= DEB_LOAD;
      end else begin
        sync1_q    <= ch_in[k];
        sync2_q    <= sync1_q;
        deb_q      <= deb_d;
        deb_prev_q <= deb_q;
        deb_cnt_q  <= deb_cnt_d;
      end
    end

    assign deb_lvl[k] = deb_q;
    assign hit[k]     = deb_q & ~deb_prev_q;

    bcd_counter #(.DIGITS(DIGITS)) u_ch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (hit[k] & count_en),
      .value (ch_bcd[k*CW +: CW]),
      .wrap  (overflow[k])
    );
  end

  coinc_state_e       state_q, state_d;
  logic [NUM_CH-1:0]  seen_q, seen_d, masked_hit, seen_next;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               fire;
  logic               coinc_pulse_q;
`ifdef COINC_DT_EN
  logic [TIMER_W-1:0] fire_time;
`endif

  assign masked_hit = hit & coinc_mask;
  assign seen_next  = seen_q | masked_hit;

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    timer_d = timer_q;
    fire    = 1'b0;
`ifdef COINC_DT_EN
    fire_time = '0;
`endif
    if (clear || !count_en) begin
      state_d = IDLE;
      seen_d  = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (masked_hit != '0) begin
            seen_d  = masked_hit;
            timer_d = TIMER_W'(1);
            if (masked_hit == coinc_mask) begin
              fire    = 1'b1;
              state_d = HOLDOFF;
            end else begin
              state_d = OPEN;
            end
          end
        end
        OPEN: begin
          seen_d = seen_next;
          if (seen_next == coinc_mask) begin
            fire    = 1'b1;
            state_d = HOLDOFF;
`ifdef COINC_DT_EN
            fire_time = timer_q;
`endif
          end else if (timer_q == TIMER_W'(WINDOW_CYCLES)) begin
            state_d = IDLE;
            seen_d  = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        HOLDOFF: begin
          if ((deb_lvl & coinc_mask) == '0) begin
            state_d = IDLE;
            seen_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      seen_q        <= '0;
      timer_q       <= '0;
      coinc_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      seen_q        <= seen_d;
      timer_q       <= timer_d;
      coinc_pulse_q <= fire;
    end
  end

  assign coinc_pulse = coinc_pulse_q;

  bcd_counter #(.DIGITS(DIGITS)) u_coinc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (fire),
    .value (coinc_bcd),
    .wrap  (overflow[NUM_CH])
  );

`ifdef COINC_DT_EN
  localparam logic [DT_W-1:0] DT_MAX = '1;
  logic [DT_W-1:0] dt_q, dt_d;
  logic            dt_valid_q;

  always_comb begin
    dt_d = dt_q;
    if (clear) begin
      dt_d = '0;
    end else if (fire) begin
      if (int'(fire_time) > int'(DT_MAX)) dt_d = DT_MAX;
      else                                dt_d = DT_W'(fire_time);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_q       <= '0;
      dt_valid_q <= 1'b0;
    end else begin
      dt_q       <= dt_d;
      dt_valid_q <= fire;
    end
  end

  assign coinc_dt       = dt_q;
  assign coinc_dt_valid = dt_valid_q;
`endif

endmodule

// File: tb/tb_coinc_counter_core.sv
// Directed bench for coinc_counter_core (3 channels, 2 digits, DEB 4, window 10) with a
// cycle-level behavioural model checked every cycle.
module tb_coinc_counter_core;

  localparam int NCH = 3;
  localparam int DEB = 4;
  localparam int WIN = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  ch_in = '0;
  logic [2:0]  coinc_mask = '0;
  logic        count_en = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] ch_bcd;
  logic [7:0]  coinc_bcd;
  logic        coinc_pulse;
  logic [3:0]  overflow;
`ifdef COINC_DT_EN
  logic [15:0] coinc_dt;
  logic        coinc_dt_valid;
`endif

  coinc_counter_core #(
    .NUM_CH(3), .DIGITS(2), .DEB_CYCLES(4), .WINDOW_CYCLES(10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_in       (ch_in),
    .coinc_mask  (coinc_mask),
    .count_en    (count_en),
    .clear       (clear),
    .ch_bcd      (ch_bcd),
    .coinc_bcd   (coinc_bcd),
    .coinc_pulse (coinc_pulse),
    .overflow    (overflow)
`ifdef COINC_DT_EN
    ,
    .coinc_dt       (coinc_dt),
    .coinc_dt_valid (coinc_dt_valid)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_pulse = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Behavioural model: integer counts, a sample history for the debouncer and a
  // window described by its start cycle rather than a timer register.
  int       m_cnt[NCH];
  int       m_ccnt;
  bit [3:0] m_ov;
  bit [2:0] m_s1, m_s2, m_lvl, m_rose, m_seen;
  bit [DEB-1:0] m_hist[NCH];
  bit       m_inwin, m_hold, m_pulse;
  int       m_start, m_now, m_dt;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_cnt[k]  = 0;
      m_hist[k] = '0;
    end
    m_ccnt = 0; m_ov = '0; m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rose = '0; m_seen = '0;
    m_inwin = 0; m_hold = 0; m_pulse = 0; m_start = 0; m_dt = 0;
  endtask

  task automatic model_step();
    bit [2:0] hits, mh;
    bit       fire;
    int       el;
    m_now++;
    hits = m_rose;
    fire = 0;
    if (clear) begin
      for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
      m_ccnt = 0; m_ov = '0; m_dt = 0;
    end else if (count_en) begin
      for (int k = 0; k < NCH; k++)
        if (hits[k]) begin
          if (m_cnt[k] == 99) begin m_cnt[k] = 0; m_ov[k] = 1; end
          else m_cnt[k]++;
        end
    end
    if (clear || !count_en) begin
      m_inwin = 0; m_hold = 0; m_seen = '0;
    end else if (m_hold) begin
      if ((m_lvl & coinc_mask) == 0) m_hold = 0;
    end else begin
      mh = hits & coinc_mask;
      if (m_inwin) begin
        m_seen |= mh;
        el = m_now - m_start;
        if (m_seen == coinc_mask) begin
          fire = 1; m_dt = el; m_inwin = 0; m_hold = 1;
        end else if (el >= WIN) begin
          m_inwin = 0; m_seen = '0;
        end
      end else if (mh != 0) begin
        m_seen = mh; m_start = m_now;
        if (mh == coinc_mask) begin fire = 1; m_dt = 0; m_hold = 1; end
        else m_inwin = 1;
      end
    end
    if (fire) begin
      if (m_ccnt == 99) begin m_ccnt = 0; m_ov[3] = 1; end
      else m_ccnt++;
    end
    m_pulse = fire;
    m_rose = '0;
    for (int k = 0; k < NCH; k++) begin
      m_hist[k] = {m_hist[k][DEB-2:0], m_s2[k]};
      if (m_lvl[k] ? (m_hist[k] == '0) : (&m_hist[k])) begin
        m_lvl[k]  = ~m_lvl[k];
        m_rose[k] = m_lvl[k];
      end
    end
    m_s2 = m_s1;
    m_s1 = ch_in;
  endtask

  initial begin
    m_now = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    logic [23:0] e_ch;
    forever begin
      @(negedge clk);
      e_ch = {bcd2(m_cnt[2]), bcd2(m_cnt[1]), bcd2(m_cnt[0])};
      check("model ch_bcd", 32'(ch_bcd), 32'(e_ch));
      check("model coinc_bcd", 32'(coinc_bcd), 32'(bcd2(m_ccnt)));
      check("model coinc_pulse", 32'(coinc_pulse), 32'(m_pulse));
      check("model overflow", 32'(overflow), 32'(m_ov));
`ifdef COINC_DT_EN
      check("model coinc_dt", 32'(coinc_dt), 32'(m_dt));
      check("model coinc_dt_valid", 32'(coinc_dt_valid), 32'(m_pulse));
`endif
      if (coinc_pulse) n_pulse++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    ch_in[ch] = 1'b1;
    cyc(hi);
    ch_in[ch] = 1'b0;
    cyc(lo);
  endtask

  initial begin
    #3;
    check("reset ch_bcd", 32'(ch_bcd), 32'h0);
    check("reset coinc_bcd", 32'(coinc_bcd), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset coinc_pulse", 32'(coinc_pulse), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    count_en = 1'b1;
    cyc(2);

    // 1: single channel, latency and five pulses
    ch_in[0] = 1'b1;
    cyc(6);
    check("latency 6 cycles", 32'(ch_bcd[7:0]), 32'h00);
    cyc(1);
    check("latency 7 cycles", 32'(ch_bcd[7:0]), 32'h01);
    cyc(1);
    ch_in[0] = 1'b0;
    cyc(8);
    for (int i = 0; i < 4; i++) pulse(0, 8, 8);
    check("t1 ch_bcd", 32'(ch_bcd), 32'h000005);
    check("t1 coinc_bcd", 32'(coinc_bcd), 32'h00);

    // 2: bounce on ch1
    for (int i = 0; i < 10; i++) begin
      ch_in[1] = ~ch_in[1];
      cyc(2);
    end
    pulse(1, 10, 8);
    check("t2 bounce", 32'(ch_bcd), 32'h000105);

    // 3: coincidence 6 apart, then 12 apart
    coinc_mask = 3'b011;
    ch_in[0] = 1'b1;
    cyc(6);
    ch_in[1] = 1'b1;
    cyc(2);
    ch_in[0] = 1'b0;
    cyc(6);
    ch_in[1] = 1'b0;
    cyc(12);
    check("t3 coinc_bcd", 32'(coinc_bcd), 32'h01);
    check("t3 pulses", 32'(n_pulse), 32'd1);
`ifdef COINC_DT_EN
    check("t3 coinc_dt", 32'(coinc_dt), 32'd6);
`endif
    pulse(0, 8, 4);
    pulse(1, 8, 20);
    check("t3 gap12", 32'(coinc_bcd), 32'h01);

    // 4: simultaneous long pulses, then window boundary at 10 and 11
    ch_in[1:0] = 2'b11;
    cyc(50);
    ch_in[1:0] = 2'b00;
    cyc(12);
    check("t4 holdoff", 32'(coinc_bcd), 32'h02);
    check("t4 pulses", 32'(n_pulse), 32'd2);
`ifdef COINC_DT_EN
    check("t4 coinc_dt same", 32'(coinc_dt), 32'd0);
`endif
    ch_in[0] = 1'b1;
    cyc(10);
    ch_in[0] = 1'b0;
    ch_in[1] = 1'b1;
    cyc(10);
    ch_in[1] = 1'b0;
    cyc(12);
    check("t4 gap10", 32'(coinc_bcd), 32'h03);
`ifdef COINC_DT_EN
    check("t4 coinc_dt gap10", 32'(coinc_dt), 32'd10);
`endif
    ch_in[0] = 1'b1;
    cyc(11);
    ch_in[0] = 1'b0;
    ch_in[1] = 1'b1;
    cyc(10);
    ch_in[1] = 1'b0;
    cyc(20);
    check("t4 gap11", 32'(coinc_bcd), 32'h03);
    check("t4 pulses end", 32'(n_pulse), 32'd3);

    // count_en low: hits ignored
    count_en = 1'b0;
    pulse(0, 8, 8);
    count_en = 1'b1;
    cyc(2);
    check("count_en hold", 32'(ch_bcd), 32'h000610);

    // 5: wrap on ch2, then clear with a same-cycle hit
    for (int i = 0; i < 99; i++) pulse(2, 5, 5);
    check("t5 ch2 99", 32'(ch_bcd[23:16]), 32'h99);
    check("t5 ovf before", 32'(overflow), 32'h0);
    pulse(2, 5, 5);
    check("t5 ch2 wrap", 32'(ch_bcd[23:16]), 32'h00);
    check("t5 ovf wrap", 32'(overflow), 32'b0100);
    ch_in[2] = 1'b1;
    cyc(6);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("t5 clear ch_bcd", 32'(ch_bcd), 32'h0);
    check("t5 clear coinc", 32'(coinc_bcd), 32'h0);
    check("t5 clear ovf", 32'(overflow), 32'h0);
    cyc(4);
    ch_in[2] = 1'b0;
    cyc(8);
    check("t5 hit dropped", 32'(ch_bcd), 32'h0);

    // 6: reset while a window is open
    ch_in[0] = 1'b1;
    cyc(8);
    rst_n = 1'b0;
    ch_in[0] = 1'b0;
    #1;
    check("t6 async ch_bcd", 32'(ch_bcd), 32'h0);
    check("t6 async coinc", 32'(coinc_bcd), 32'h0);
    check("t6 async ovf", 32'(overflow), 32'h0);
    check("t6 async pulse", 32'(coinc_pulse), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    pulse(1, 10, 20);
    check("t6 lone ch1 coinc", 32'(coinc_bcd), 32'h00);
    check("t6 lone ch1 count", 32'(ch_bcd), 32'h000100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
